// File: rtl/core_step_ctrl_if.sv
// Bus between the single-step/run controller and its environment: raw operator
// inputs, breakpoint match inputs, and the core enable / status outputs.
interface core_step_ctrl_if;
    logic        step_btn_i;
    logic        run_sw_i;
    logic        bp_en_i;
    logic [31:0] bp_addr_i;
    logic [31:0] instr_addr_i;
    logic        core_en_o;
    logic [1:0]  state_o;
    logic [15:0] step_cnt_o;

    modport master (
        output step_btn_i, run_sw_i, bp_en_i, bp_addr_i, instr_addr_i,
        input  core_en_o, state_o, step_cnt_o
    );

    modport slave (
        input  step_btn_i, run_sw_i, bp_en_i, bp_addr_i, instr_addr_i,
        output core_en_o, state_o, step_cnt_o
    );
endinterface

// File: rtl/core_step_ctrl.sv
// Single-step / free-run / breakpoint controller producing one-cycle core enables
// from a debounced step button and run switch.
module core_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    core_step_ctrl_if.slave   bus
);
    localparam int NUM_IN = 2;  // lane 0 = step button, lane 1 = run switch
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W   = $clog2(RUN_DIV + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    logic [NUM_IN-1:0]           raw;
    logic [NUM_IN-1:0]           sync1;
    logic [NUM_IN-1:0]           sync2;
    logic [NUM_IN-1:0]           stable;
    logic [NUM_IN-1:0]           stable_d1;
    logic [NUM_IN-1:0][DB_W-1:0] db_cnt;

    state_t          state_q;
    state_t          state_d;
    logic [PS_W-1:0] presc_q;
    logic            first_q;
    logic            bp_hit_q;
    logic [15:0]     cnt_q;

    logic run_lvl;
    logic step_req;
    logic tick;
    logic core_en;

    assign raw = {bus.run_sw_i, bus.step_btn_i};

    // Synchronize, then require DEBOUNCE_CYCLES consecutive mismatches to flip.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            stable_d1 <= '0;
            db_cnt    <= '0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            stable_d1 <= stable;
            for (int l = 0; l < NUM_IN; l++) begin
                if (sync2[l] == stable[l]) begin
                    db_cnt[l] <= '0;
                end else if (db_cnt[l] == DB_MAX) begin
                    stable[l] <= sync2[l];
                    db_cnt[l] <= '0;
                end else begin
                    db_cnt[l] <= db_cnt[l] + 1'b1;
                end
            end
        end
    end

    assign run_lvl  = stable[1];
    assign step_req = stable[0] & ~stable_d1[0];
    assign tick     = (state_q == S_RUN) && (presc_q == PS_MAX);

    // Enable is decoded only from flops so it cannot glitch on input activity.
    assign core_en = (state_q == S_STEP) ||
                     (tick && run_lvl && !(bp_hit_q && !first_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_lvl)       state_d = S_RUN;
                else if (step_req) state_d = S_STEP;
            end
            S_STEP: state_d = S_IDLE;
            S_RUN: begin
                if (!run_lvl)                           state_d = S_IDLE;
                else if (tick && bp_hit_q && !first_q)  state_d = S_BRK;
            end
            S_BRK: begin
                if (!run_lvl)      state_d = S_IDLE;
                else if (step_req) state_d = S_STEP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Prescaler only runs while staying in RUN, so every entry starts from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            first_q  <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bus.bp_en_i && (bus.instr_addr_i == bus.bp_addr_i);
            if (state_q == S_RUN && state_d == S_RUN)
                presc_q <= tick ? '0 : presc_q + 1'b1;
            else
                presc_q <= '0;
            if (state_q != S_RUN) first_q <= 1'b1;
            else if (tick)        first_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        cnt_q <= '0;
        else if (core_en) cnt_q <= cnt_q + 16'd1;
    end

    assign bus.core_en_o  = core_en;
    assign bus.state_o    = state_q;
    assign bus.step_cnt_o = cnt_q;
endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed bench for core_step_ctrl: stepping, bounce rejection, free run,
// breakpoint, reset abort and step counter wrap.
module tb_core_step_ctrl;
    localparam int DB  = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    core_step_ctrl_if bus ();
    core_step_ctrl_if bus2 ();

    core_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    // Fastest legal configuration, used only to reach the counter wrap quickly.
    core_step_ctrl #(.DEBOUNCE_CYCLES(1), .RUN_DIV(1)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .bus(bus2)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.step_btn_i    = 1'b0;
        bus.run_sw_i      = 1'b0;
        bus.bp_en_i       = 1'b0;
        bus.bp_addr_i     = 32'h0;
        bus.instr_addr_i  = 32'h0;
        bus2.step_btn_i   = 1'b0;
        bus2.run_sw_i     = 1'b0;
        bus2.bp_en_i      = 1'b0;
        bus2.bp_addr_i    = 32'h0;
        bus2.instr_addr_i = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #3;
        n_cmp++;
        if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", bus.state_o); end
        n_cmp++;
        if (bus.core_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_en got=%b exp=0", bus.core_en_o); end
        n_cmp++;
        if (bus.step_cnt_o !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got=%h exp=0000", bus.step_cnt_o); end
        n_cmp++;
        if (bus2.step_cnt_o !== 16'h0 || bus2.state_o !== 2'b00) begin
            n_bad++; $display("FAIL reset_wrap_dut cnt=%h state=%b exp 0000/00", bus2.step_cnt_o, bus2.state_o);
        end
        apply_reset();
    endtask

    task automatic test_single_step();
        logic exp;
        apply_reset();
        bus.step_btn_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            clk_step();
            exp = (i == 7);
            n_cmp++;
            if (bus.core_en_o !== exp) begin n_bad++; $display("FAIL step_en cyc=%0d got=%b exp=%b", i, bus.core_en_o, exp); end
            if (i == 7) begin
                n_cmp++;
                if (bus.state_o !== 2'b01) begin n_bad++; $display("FAIL step_state cyc=7 got=%b exp=01", bus.state_o); end
            end
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd1) begin n_bad++; $display("FAIL step_cnt got=%0d exp=1", bus.step_cnt_o); end
        n_cmp++;
        if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL step_back_idle got=%b exp=00", bus.state_o); end
        bus.step_btn_i = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            clk_step();
            n_cmp++;
            if (bus.core_en_o !== 1'b0) begin n_bad++; $display("FAIL release_en cyc=%0d got=%b exp=0", i, bus.core_en_o); end
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd1) begin n_bad++; $display("FAIL release_cnt got=%0d exp=1", bus.step_cnt_o); end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            if (i < 20 && (i % 2) == 0) bus.step_btn_i = ~bus.step_btn_i;
            if (i == 20) bus.step_btn_i = 1'b0;
            clk_step();
            n_cmp++;
            if (bus.core_en_o !== 1'b0 || bus.state_o !== 2'b00) begin
                n_bad++; $display("FAIL bounce cyc=%0d en=%b state=%b exp 0/00", i, bus.core_en_o, bus.state_o);
            end
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd0) begin n_bad++; $display("FAIL bounce_cnt got=%0d exp=0", bus.step_cnt_o); end
    endtask

    task automatic test_run();
        logic exp;
        logic prev_en;
        apply_reset();
        bus.run_sw_i = 1'b1;
        prev_en = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            clk_step();
            exp = (i >= 14) && (((i - 14) % DIV) == 0);
            n_cmp++;
            if (bus.core_en_o !== exp) begin n_bad++; $display("FAIL run_en cyc=%0d got=%b exp=%b", i, bus.core_en_o, exp); end
            n_cmp++;
            if (bus.core_en_o && prev_en) begin n_bad++; $display("FAIL run_adjacent cyc=%0d got=1 exp=0", i); end
            prev_en = bus.core_en_o;
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd11) begin n_bad++; $display("FAIL run_cnt got=%0d exp=11", bus.step_cnt_o); end
        n_cmp++;
        if (bus.state_o !== 2'b10) begin n_bad++; $display("FAIL run_state got=%b exp=10", bus.state_o); end
        bus.run_sw_i = 1'b0;
        repeat (12) clk_step();
        n_cmp++;
        if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL run_off_state got=%b exp=00", bus.state_o); end
    endtask

    task automatic test_breakpoint();
        logic       exp;
        logic [1:0] exp_st;
        apply_reset();
        bus.bp_en_i   = 1'b1;
        bus.bp_addr_i = 32'h10;
        bus.run_sw_i  = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            clk_step();
            exp = (i == 14) || (i == 22);
            n_cmp++;
            if (bus.core_en_o !== exp) begin n_bad++; $display("FAIL bp_en cyc=%0d got=%b exp=%b", i, bus.core_en_o, exp); end
            if (i == 22) bus.instr_addr_i = 32'h10;
        end
        n_cmp++;
        if (bus.state_o !== 2'b11) begin n_bad++; $display("FAIL bp_state got=%b exp=11", bus.state_o); end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd2) begin n_bad++; $display("FAIL bp_cnt got=%0d exp=2", bus.step_cnt_o); end
        bus.step_btn_i = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            clk_step();
            exp    = (j == 7) || (j == 16);
            exp_st = (j < 7) ? 2'b11 : (j == 7) ? 2'b01 : (j == 8) ? 2'b00 : 2'b10;
            n_cmp++;
            if (bus.core_en_o !== exp) begin n_bad++; $display("FAIL brk_step_en cyc=%0d got=%b exp=%b", j, bus.core_en_o, exp); end
            n_cmp++;
            if (bus.state_o !== exp_st) begin n_bad++; $display("FAIL brk_step_state cyc=%0d got=%b exp=%b", j, bus.state_o, exp_st); end
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd3) begin n_bad++; $display("FAIL brk_step_cnt got=%0d exp=3", bus.step_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_run();
        logic       exp;
        logic [1:0] exp_st;
        apply_reset();
        bus.run_sw_i = 1'b1;
        repeat (22) clk_step();
        n_cmp++;
        if (bus.core_en_o !== 1'b1) begin n_bad++; $display("FAIL pre_abort_en got=%b exp=1", bus.core_en_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.core_en_o !== 1'b0) begin n_bad++; $display("FAIL abort_en got=%b exp=0", bus.core_en_o); end
        n_cmp++;
        if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL abort_state got=%b exp=00", bus.state_o); end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd0) begin n_bad++; $display("FAIL abort_cnt got=%0d exp=0", bus.step_cnt_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            clk_step();
            exp    = (i == 14);
            exp_st = (i <= 6) ? 2'b00 : 2'b10;
            n_cmp++;
            if (bus.core_en_o !== exp) begin n_bad++; $display("FAIL redebounce_en cyc=%0d got=%b exp=%b", i, bus.core_en_o, exp); end
            n_cmp++;
            if (bus.state_o !== exp_st) begin n_bad++; $display("FAIL redebounce_state cyc=%0d got=%b exp=%b", i, bus.state_o, exp_st); end
        end
        n_cmp++;
        if (bus.step_cnt_o !== 16'd0) begin n_bad++; $display("FAIL redebounce_cnt got=%0d exp=0", bus.step_cnt_o); end
        bus.run_sw_i = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus2.run_sw_i = 1'b1;
        repeat (65539) clk_step();
        n_cmp++;
        if (bus2.step_cnt_o !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload got=%h exp=ffff", bus2.step_cnt_o); end
        n_cmp++;
        if (bus2.core_en_o !== 1'b1) begin n_bad++; $display("FAIL wrap_en got=%b exp=1", bus2.core_en_o); end
        clk_step();
        n_cmp++;
        if (bus2.step_cnt_o !== 16'h0000) begin n_bad++; $display("FAIL wrap_cnt got=%h exp=0000", bus2.step_cnt_o); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bounce();
        test_run();
        test_breakpoint();
        test_reset_mid_run();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_step_ctrl.md
CORE_STEP_CTRL -- requirements
Module: core_step_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive cycles a synchronized input must differ from its stable value before that value changes.
REQ-002 The block SHALL have parameter RUN_DIV, default 50000000, meaning the number of clock cycles between core enable pulses in RUN.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port step_btn_i, input, 1 bit: raw single-step button, asynchronous to clk_i and bouncing.
REQ-006 The block SHALL have port run_sw_i, input, 1 bit: raw run switch level, asynchronous to clk_i and bouncing.
REQ-007 The block SHALL have port bp_en_i, input, 1 bit: breakpoint enable.
REQ-008 The block SHALL have port bp_addr_i, input, 32 bits: breakpoint instruction address.
REQ-009 The block SHALL have port instr_addr_i, input, 32 bits: the core's current instruction address.
REQ-010 The block SHALL have port core_en_o, output, 1 bit: core clock-enable, asserted for 1 cycle per instruction to execute.
REQ-011 The block SHALL have port state_o, output, 2 bits: current FSM state encoding.
REQ-012 The block SHALL have port step_cnt_o, output, 16 bits: the count of issued core_en_o pulses.

Function
REQ-013 step_btn_i and run_sw_i SHALL each pass through a 2-flop synchronizer.
REQ-014 Each synchronized input SHALL have its own debounce counter:
- The counter clears whenever the synchronized value equals the stable value.
- The counter increments on each mismatching cycle.
- When the counter equals DEBOUNCE_CYCLES-1 and the input still mismatches, the stable value takes the input and the counter clears.
REQ-015 step_req SHALL be a 1-cycle pulse on the 0->1 transition of the debounced step value; 1->0 transitions produce no request.
REQ-016 The FSM SHALL have the states IDLE=2'b00, STEP=2'b01, RUN=2'b10 and BREAK=2'b11, and state_o SHALL equal the current state.
REQ-017 In IDLE:
- a debounced run value of 1 moves the FSM to RUN; this has priority over a simultaneous step_req;
- otherwise step_req moves the FSM to STEP;
- otherwise the FSM stays in IDLE.
REQ-018 STEP SHALL last exactly 1 cycle, during which core_en_o=1, and then return to IDLE.
REQ-019 In RUN, a prescaler SHALL count from 0 to RUN_DIV-1 and wrap; the prescaler clears on entry to RUN.
REQ-020 At prescaler==RUN_DIV-1 in RUN, the tick SHALL resolve as follows:
- If bp_en_i=1, instr_addr_i==bp_addr_i, and this is not the first tick since entering RUN, the FSM moves to BREAK with no pulse.
- Otherwise core_en_o=1 for that cycle.
REQ-021 In RUN, a debounced run value of 0 SHALL move the FSM to IDLE, clear the prescaler, and issue no pulse; step_req SHALL be ignored.
REQ-022 In BREAK, core_en_o SHALL be 0.
- step_req moves the FSM to STEP.
- A debounced run value of 0 moves the FSM to IDLE.
- If both occur, IDLE wins.
REQ-023 In STEP entered from BREAK, the FSM SHALL return to IDLE, and then to RUN on the next cycle if the debounced run value is still 1.
REQ-024 core_en_o SHALL be a glitch-free state/prescaler decode that is never high in 2 consecutive cycles.
REQ-025 step_cnt_o SHALL increment by 1 in each cycle where core_en_o=1, wrapping from 16'hFFFF to 16'h0000.
REQ-026 Step latency SHALL be fixed: after step_btn_i rises and stays stable, core_en_o is high in the cycle following the (DEBOUNCE_CYCLES+3)rd clock edge, counted from the first edge that samples step_btn_i=1.
REQ-027 Bounces shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no state change.

Reset
REQ-028 While rst_i=1, the following SHALL hold immediately and without waiting for a clock edge:
- state_o=IDLE, core_en_o=0, step_cnt_o=0;
- synchronizers, stable values and debounce counters =0;
- prescaler =0.
REQ-029 Reset asserted mid-RUN or mid-STEP SHALL abort with no further core_en_o pulse.
REQ-030 After rst_i deasserts, a run_sw_i already held at 1 SHALL enter RUN only after full debounce.

Verification
REQ-031 The bench SHALL cover the scenario: DEBOUNCE_CYCLES=4, RUN_DIV=8; step_btn_i high with no bounce -> exactly one core_en_o pulse, 7 edges after the first sampled high; step_cnt_o=1; state_o returns to 00.
REQ-032 The bench SHALL cover the scenario: step_btn_i toggled every 2 cycles for 20 cycles, then held low -> no core_en_o, state_o=00 throughout.
REQ-033 The bench SHALL cover the scenario: run_sw_i=1 held for 100 cycles, bp_en_i=0 -> core_en_o pulses spaced exactly 8 cycles apart, never in adjacent cycles, and step_cnt_o equals the pulse count.
REQ-034 The bench SHALL cover the scenario: RUN with bp_en_i=1 and bp_addr_i=32'h10, with instr_addr_i set to 32'h10 after the 2nd pulse -> state_o=11 at the next tick with no pulse; then a step press -> one pulse, state 01 -> 00 -> 10.
REQ-035 The bench SHALL cover the scenario: step_cnt_o preloaded near wrap by 65535 pulses, plus one more pulse -> step_cnt_o=16'h0000.
REQ-036 The bench SHALL cover the scenario: rst_i asserted mid-RUN between clock edges -> core_en_o=0, state_o=00 and step_cnt_o=0 immediately, and no pulse until after rst_i deasserts and run_sw_i is re-debounced.
